serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial two's-complement adder/subtractor: takes two WIDTH-bit operands and a mode bit, then processes one bit per clock through a single full-adder slice with a registered carry. It is the sequential, subtract-capable counterpart of the 4-bit ripple-carry adder built from `hw3p2` slices. It trades WIDTH cycles of latency for one adder cell, and its results must match the ripple adder for addition.

## Interface
- WIDTH, 4, operand and result width in bits (legal values 2..32).
- CLK  input  1  rising-edge clock.
- RSTN  input  1  asynchronous active-low reset.
- START  input  1  request to begin an operation; sampled only when not busy.
- SUB  input  1  mode: 0 = A+B, 1 = A−B; sampled with START.
- A  input  WIDTH  minuend/addend; sampled with START.
- B  input  WIDTH  subtrahend/addend; sampled with START.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse when S/COUT/OVF update.
- S  output  WIDTH  result, held until the next DONE.
- COUT  output  1  final carry out. Add: 1 = unsigned overflow. Sub: 1 = no borrow (A ≥ B unsigned).
- OVF  output  1  signed overflow flag (see Configuration).

## Operation
- States: IDLE, SHIFT, FIN. Reset state is IDLE.
- IDLE, START=1 at an edge:
  - Latch A into opA.
  - Latch B into opB, or ~B if SUB=1.
  - Set carry register to SUB.
  - Clear bit counter to 0.
  - Go to SHIFT.
- SHIFT, every edge:
  - sum = opA[0]^opB[0]^carry.
  - carry = majority(opA[0], opB[0], carry).
  - Shift sum into the MSB of the internal result shift register.
  - Shift opA and opB right by one.
  - Increment the counter.
  - Before the MSB step (counter = WIDTH−1), save the incoming carry as cmsb.
  - At the WIDTH-th step: copy the result register to S, the new carry to COUT, and cmsb^carry to OVF. Go to FIN.
- FIN: DONE=1 for exactly this one cycle, then return to IDLE.
- START in FIN is accepted as if in IDLE, so back-to-back operations are allowed and DONE is not extended.
- START while in SHIFT is ignored. Operands and mode are not resampled.
- Arithmetic is modulo 2^WIDTH. S never changes except at the DONE-producing edge.
- Reset (any time, including mid-operation) asynchronously forces:
  - state IDLE;
  - all operand, counter and carry registers to 0;
  - outputs S=0, COUT=0, OVF=0, BUSY=0, DONE=0.
- The interrupted operation is lost. No partial result is exposed.

## Timing
- START sampled at edge 0. SHIFT steps occur at edges 1..WIDTH. S/COUT/OVF update at edge WIDTH.
- BUSY is registered: high in the cycles following edges 0..WIDTH−1 (WIDTH cycles), low from edge WIDTH.
- DONE is registered: high in the cycle following edge WIDTH only.
- Latency from START edge to DONE-high edge: WIDTH cycles. Throughput: one operation per WIDTH+1 cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - cmsb register and overflow logic compiled in.
  - OVF = signed overflow of the last operation, updated with S.
- Not defined:
  - cmsb and overflow logic removed.
  - OVF port still present, tied to constant 0.
  - All other behaviour unchanged.

## Test plan
- Reset, then idle 5 cycles → S=0, COUT=0, OVF=0, BUSY=0, DONE=0. Pulse RSTN low during a SHIFT step → all outputs 0 immediately; no DONE afterwards.
- WIDTH=4, A=6, B=3, SUB=1, START for 1 cycle → BUSY high 4 cycles. DONE pulse 4 edges after START with S=3, COUT=1, OVF=0.
- A=3, B=6, SUB=1 → S=13 (0xD), COUT=0 (borrow), OVF=0. A=9, B=9, SUB=0 → S=2, COUT=1, OVF=1 (−7+−7).
- Overflow, with macro defined: A=7, B=15, SUB=1 → S=8, COUT=0, OVF=1. A=5, B=4, SUB=0 → S=9, COUT=0, OVF=1. Without the macro, OVF stays 0 in both cases.
- Change A/B/SUB and hold START high during SHIFT → result reflects the originally latched operands; START in the FIN cycle launches the next operation, whose DONE follows 4 edges later.
- Exhaustive WIDTH=4 sweep over all A, B, SUB (512 ops) against a reference model: S, COUT and OVF match, and DONE pulses exactly once per operation.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice, WIDTH cycles per operation.
// Optional signed-overflow flag compiled in with `define SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-2:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             sum_c;
  logic             carry_nxt_c;
  logic [WIDTH-1:0] res_full_c;

  // Single full-adder slice on the operand LSBs.
  assign sum_c       = op_a[0] ^ op_b[0] ^ carry;
  assign carry_nxt_c = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign res_full_c  = {sum_c, res};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and datapath controls; FIN accepts START like IDLE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        if (START) begin
          load      = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      S     <= '0;
      COUT  <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      BUSY <= (state_nxt == ST_SHIFT);
      DONE <= (state_nxt == ST_FIN);
      if (load) begin
        // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
        op_a  <= A;
        op_b  <= SUB ? ~B : B;
        carry <= SUB;
        cnt   <= '0;
      end else if (step) begin
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        res   <= res_full_c[WIDTH-1:1];
        carry <= carry_nxt_c;
        cnt   <= cnt + CW'(1);
        if (last) begin
          S    <= res_full_c;
          COUT <= carry_nxt_c;
        end
      end
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic cmsb_c;

  // On the last step the carry register holds the carry into the MSB.
  assign cmsb_c = carry;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)            OVF <= 1'b0;
    else if (step && last) OVF <= cmsb_c ^ carry_nxt_c;
  end
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4): vector table, corner sequences, random and exhaustive sweep.
module tb_serial_addsub;

  localparam int unsigned W = 4;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rstn;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .START(start),
    .SUB  (sub),
    .A    (a),
    .B    (b),
    .BUSY (busy),
    .DONE (done),
    .S    (s),
    .COUT (cout),
    .OVF  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  // Reference from plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub);
    res_t r;
    int ua = int'(ma);
    int ub = int'(mb);
    int sa = ma[W-1] ? ua - (1 << W) : ua;
    int sb = mb[W-1] ? ub - (1 << W) : ub;
    int ru;
    int rs;
    if (msub) begin
      ru     = ua - ub;
      rs     = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      ru     = ua + ub;
      rs     = sa + sb;
      r.cout = (ru >= (1 << W));
    end
    r.s   = W'(ru);
    r.ovf = OVF_ON && ((rs > (1 << (W - 1)) - 1) || (rs < -(1 << (W - 1))));
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for DONE after the launch edge; returns cycles taken and BUSY-high cycles seen.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (busy) busy_cycles++;
    end
  endtask

  // One complete operation; called #1 after an edge with START low.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tsub, input res_t exp, input bit full);
    int lat;
    int bc;
    a = ta; b = tb; sub = tsub; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    check({tag, "_latency"}, lat, W);
    check({tag, "_s"}, int'(s), int'(exp.s));
    check({tag, "_cout"}, int'(cout), int'(exp.cout));
    check({tag, "_ovf"}, int'(ovf), int'(exp.ovf));
    if (full) check({tag, "_busy_cycles"}, bc, W);
    tick();
    if (full) check({tag, "_done_width"}, int'(done), 0);
  endtask

  vec_t vecs[10];

  initial begin
    int   lat;
    int   bc;
    int   d0;
    res_t e;

    vecs[0] = '{a: 4'd6,  b: 4'd3,  sub: 1'b1, s: 4'd3,  cout: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 4'd3,  b: 4'd6,  sub: 1'b1, s: 4'd13, cout: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 4'd9,  b: 4'd9,  sub: 1'b0, s: 4'd2,  cout: 1'b1, ovf: 1'b1};
    vecs[3] = '{a: 4'd7,  b: 4'd15, sub: 1'b1, s: 4'd8,  cout: 1'b0, ovf: 1'b1};
    vecs[4] = '{a: 4'd5,  b: 4'd4,  sub: 1'b0, s: 4'd9,  cout: 1'b0, ovf: 1'b1};
    vecs[5] = '{a: 4'd0,  b: 4'd0,  sub: 1'b0, s: 4'd0,  cout: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd1,  sub: 1'b0, s: 4'd0,  cout: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 4'd0,  b: 4'd1,  sub: 1'b1, s: 4'd15, cout: 1'b0, ovf: 1'b0};
    vecs[8] = '{a: 4'd8,  b: 4'd1,  sub: 1'b1, s: 4'd7,  cout: 1'b1, ovf: 1'b1};
    vecs[9] = '{a: 4'd0,  b: 4'd0,  sub: 1'b1, s: 4'd0,  cout: 1'b1, ovf: 1'b0};

    rstn = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) tick();
    check("rst_s", int'(s), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    // Table of hand-computed vectors.
    foreach (vecs[i]) begin
      e.s    = vecs[i].s;
      e.cout = vecs[i].cout;
      e.ovf  = OVF_ON & vecs[i].ovf;
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, e, 1'b1);
    end

    // START held and operands changed during SHIFT; START in FIN launches the next op.
    a = 4'd6; b = 4'd3; sub = 1'b1; start = 1'b1;
    tick();
    a = 4'd15; b = 4'd15; sub = 1'b0;
    wait_done(lat, bc);
    check("hold_latency", lat, W);
    check("hold_s", int'(s), 3);
    check("hold_cout", int'(cout), 1);
    tick();
    start = 1'b0;
    check("b2b_done_not_extended", int'(done), 0);
    check("b2b_busy", int'(busy), 1);
    wait_done(lat, bc);
    check("b2b_latency", lat, W);
    check("b2b_s", int'(s), 14);
    check("b2b_cout", int'(cout), 1);
    check("b2b_ovf", int'(ovf), 0);
    tick();

    // Reset asserted mid-SHIFT clears everything and no DONE follows.
    d0 = done_cnt;
    a = 4'd2; b = 4'd1; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rstn = 1'b0;
    #1;
    check("midrst_s", int'(s), 0);
    check("midrst_cout", int'(cout), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_ovf", int'(ovf), 0);
    #3 rstn = 1'b1;
    repeat (8) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle_busy", int'(busy), 0);

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d_a%0d_b%0d_sub%0d", i, ra, rb, rs), ra, rb, rs, model(ra, rb, rs), 1'b1);
    end

    // Exhaustive sweep.
    d0 = done_cnt;
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < (1 << W); x++) begin
        for (int y = 0; y < (1 << W); y++) begin
          run_op($sformatf("sw_a%0d_b%0d_sub%0d", x, y, m), W'(x), W'(y), 1'(m),
                 model(W'(x), W'(y), 1'(m)), 1'b0);
        end
      end
    end
    check("sweep_done_pulses", done_cnt - d0, 2 * (1 << W) * (1 << W));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
